// File: rtl/alarm_pkg.sv
// Encodings shared by the clock/LCD FSM and the alarm buzzer controller,
// plus the counter-width helper used by the buzzer blocks.
package alarm_pkg;

  typedef enum logic [3:0] {
    INITIAL_DELAY      = 4'b0000,
    SHOW_TIME          = 4'b0001,
    SET_HOUR           = 4'b0010,
    SET_MINUTE         = 4'b0011,
    SET_ALARM_HOUR     = 4'b0100,
    SET_ALARM_MINUTE   = 4'b0101,
    ALARM_TIME_REACHED = 4'b1010
  } clk_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RING = 2'b01,
    SNZ  = 2'b10
  } buz_state_e;

  // Bits needed to hold 0..limit; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Millisecond and second strobes derived from the system clock; a synchronous
// clear restarts both so that time is measured from the clear edge.
module alarm_tick_gen import alarm_pkg::*; #(
  parameter int CLK_HZ = 1000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic ms_tick_o,
  output logic s_tick_o
);

  localparam int MS_DIV = ((CLK_HZ / 1000) > 0) ? (CLK_HZ / 1000) : 1;
  localparam int MS_W   = cnt_w(MS_DIV);
  localparam int SEC_W  = cnt_w(1000);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(999);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             ms_wrap_s;

  assign ms_wrap_s = (ms_cnt_q == MS_LAST);
  assign ms_tick_o = ms_wrap_s & ~clear_i;
  assign s_tick_o  = ms_tick_o & (sec_cnt_q == SEC_LAST);

  // Next-state for the millisecond prescaler and the per-second ms counter.
  always_comb begin
    ms_cnt_d  = ms_cnt_q;
    sec_cnt_d = sec_cnt_q;
    if (clear_i) begin
      ms_cnt_d  = '0;
      sec_cnt_d = '0;
    end else if (ms_wrap_s) begin
      ms_cnt_d = '0;
      if (sec_cnt_q == SEC_LAST) begin
        sec_cnt_d = '0;
      end else begin
        sec_cnt_d = sec_cnt_q + SEC_ONE;
      end
    end else begin
      ms_cnt_d = ms_cnt_q + MS_ONE;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ms_cnt_q  <= '0;
      sec_cnt_q <= '0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Piezo buzzer driver: rings with a cadenced tone when the clock FSM reaches
// its alarm state. Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_buzzer_ctrl import alarm_pkg::*; #(
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] ALARM_STATE = STATE_W'(ALARM_TIME_REACHED),
  parameter int                 CLK_HZ      = 1000000,
  parameter int                 TONE_HZ     = 2000,
  parameter int                 BEEP_ON_MS  = 200,
  parameter int                 BEEP_OFF_MS = 200,
  parameter int                 TIMEOUT_S   = 60,
  parameter int                 SNOOZE_S    = 300
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [STATE_W-1:0] state_i,
  input  logic               stop_i,
  input  logic               snooze_i,
  output logic               buzzer_o,
  output logic               ringing_o,
  output logic               snoozed_o
);

  localparam int HP_RAW  = CLK_HZ / (2 * TONE_HZ);
  localparam int HP      = (HP_RAW > 0) ? HP_RAW : 1;
  localparam int TONE_W  = cnt_w(HP);
  localparam int CAD_MAX = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
  localparam int CAD_W   = cnt_w(CAD_MAX);
  localparam int TO_W    = cnt_w(TIMEOUT_S);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HP - 1);
  localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
  localparam logic [CAD_W-1:0]  ON_LAST   = CAD_W'((BEEP_ON_MS > 0) ? BEEP_ON_MS - 1 : 0);
  localparam logic [CAD_W-1:0]  OFF_LAST  = CAD_W'((BEEP_OFF_MS > 0) ? BEEP_OFF_MS - 1 : 0);
  localparam logic [CAD_W-1:0]  CAD_ONE   = CAD_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam bit                TO_EN     = (TIMEOUT_S != 0);

  buz_state_e        fsm_q, fsm_d;
  logic              hit_q, hit_s, trig_s, timeout_s;
  logic              ring_entry_s, snz_entry_s;
  logic              ms_tick_s, s_tick_s;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;
  logic [CAD_W-1:0]  cad_cnt_q, cad_cnt_d;
  logic              cad_on_q, cad_on_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              buzzer_q, ringing_q;

  assign hit_s     = (state_i == ALARM_STATE);
  assign trig_s    = hit_s & ~hit_q;
  assign timeout_s = TO_EN & s_tick_s & (to_cnt_q == TO_LAST);

  alarm_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (ring_entry_s | snz_entry_s),
    .ms_tick_o (ms_tick_s),
    .s_tick_o  (s_tick_s)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = cnt_w(SNOOZE_S);
  localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'((SNOOZE_S > 0) ? SNOOZE_S - 1 : 0);
  localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             snoozed_q, snz_done_s;

  assign snz_done_s = s_tick_s & (snz_cnt_q == SNZ_LAST);
  assign snoozed_o  = snoozed_q;

  // Snooze duration counter, restarted on every entry into SNZ.
  always_comb begin
    snz_cnt_d = snz_cnt_q;
    if (snz_entry_s) begin
      snz_cnt_d = '0;
    end else if ((fsm_q == SNZ) && s_tick_s) begin
      snz_cnt_d = (snz_cnt_q == SNZ_LAST) ? '0 : snz_cnt_q + SNZ_ONE;
    end else begin
      snz_cnt_d = snz_cnt_q;
    end
  end

  // Snooze registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snz_cnt_q <= '0;
      snoozed_q <= 1'b0;
    end else begin
      snz_cnt_q <= snz_cnt_d;
      snoozed_q <= (fsm_d == SNZ);
    end
  end
`else
  localparam int unused_snooze_s = SNOOZE_S;
  logic unused_snooze_in;
  assign unused_snooze_in = snooze_i;
  assign snoozed_o        = 1'b0;
`endif

  // FSM transitions; STOP outranks timeout, which outranks SNOOZE.
  always_comb begin
    fsm_d        = fsm_q;
    ring_entry_s = 1'b0;
    snz_entry_s  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (trig_s) begin
          fsm_d        = RING;
          ring_entry_s = 1'b1;
        end else begin
          fsm_d = IDLE;
        end
      end
      RING: begin
        if (stop_i) begin
          fsm_d = IDLE;
        end else if (timeout_s) begin
          fsm_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_i) begin
          fsm_d       = SNZ;
          snz_entry_s = 1'b1;
`endif
        end else begin
          fsm_d = RING;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNZ: begin
        if (stop_i) begin
          fsm_d = IDLE;
        end else if (snz_done_s) begin
          fsm_d        = RING;
          ring_entry_s = 1'b1;
        end else begin
          fsm_d = SNZ;
        end
      end
`endif
      default: fsm_d = IDLE;
    endcase
  end

  // Tone, cadence and timeout counters; all restart on RING entry.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    cad_cnt_d  = cad_cnt_q;
    cad_on_d   = cad_on_q;
    to_cnt_d   = to_cnt_q;
    if (ring_entry_s) begin
      tone_cnt_d = '0;
      tone_d     = 1'b1;
      cad_cnt_d  = '0;
      cad_on_d   = 1'b1;
      to_cnt_d   = '0;
    end else if (fsm_q == RING) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_ONE;
      end
      if (ms_tick_s) begin
        if (cad_cnt_q == (cad_on_q ? ON_LAST : OFF_LAST)) begin
          cad_cnt_d = '0;
          cad_on_d  = ~cad_on_q;
        end else begin
          cad_cnt_d = cad_cnt_q + CAD_ONE;
        end
      end else begin
        cad_cnt_d = cad_cnt_q;
      end
      if (s_tick_s) begin
        to_cnt_d = (to_cnt_q == TO_LAST) ? '0 : to_cnt_q + TO_ONE;
      end else begin
        to_cnt_d = to_cnt_q;
      end
    end else begin
      tone_cnt_d = tone_cnt_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q      <= IDLE;
      hit_q      <= 1'b0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      cad_cnt_q  <= '0;
      cad_on_q   <= 1'b0;
      to_cnt_q   <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      hit_q      <= hit_s;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      cad_cnt_q  <= cad_cnt_d;
      cad_on_q   <= cad_on_d;
      to_cnt_q   <= to_cnt_d;
      buzzer_q   <= (fsm_d == RING) & cad_on_d & tone_d;
      ringing_q  <= (fsm_d == RING);
    end
  end

  assign buzzer_o  = buzzer_q;
  assign ringing_o = ringing_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Scoreboard bench for alarm_buzzer_ctrl: stimulus queues expected
// BUZZER/RINGING/SNOOZED values per cycle, a negedge monitor compares them.
module tb_alarm_buzzer_ctrl;

  localparam int CLK_HZ      = 8000;
  localparam int TONE_HZ     = 1000;
  localparam int BEEP_ON_MS  = 2;
  localparam int BEEP_OFF_MS = 2;
  localparam int TIMEOUT_S   = 1;
  localparam int SNOOZE_S    = 1;
  localparam int HP          = CLK_HZ / (2 * TONE_HZ);
  localparam int MS_CYC      = CLK_HZ / 1000;
  localparam int ON_CYC      = BEEP_ON_MS * MS_CYC;
  localparam int PERIOD      = (BEEP_ON_MS + BEEP_OFF_MS) * MS_CYC;
  localparam int TO_CYC      = TIMEOUT_S * CLK_HZ;
  localparam int SNZ_CYC     = SNOOZE_S * CLK_HZ;
  localparam logic [3:0] ALARM = 4'b1010;
  localparam logic [3:0] OTHER = 4'b1000;

  logic       clk = 1'b0;
  logic       reset, stop, snooze;
  logic [3:0] state;
  logic       buzzer, ringing, snoozed;

  typedef struct packed {
    int   cyc;
    logic b;
    logic r;
    logic s;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_lost = 0;

  alarm_buzzer_ctrl #(
    .STATE_W     (4),
    .ALARM_STATE (ALARM),
    .CLK_HZ      (CLK_HZ),
    .TONE_HZ     (TONE_HZ),
    .BEEP_ON_MS  (BEEP_ON_MS),
    .BEEP_OFF_MS (BEEP_OFF_MS),
    .TIMEOUT_S   (TIMEOUT_S),
    .SNOOZE_S    (SNOOZE_S)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .state_i   (state),
    .stop_i    (stop),
    .snooze_i  (snooze),
    .buzzer_o  (buzzer),
    .ringing_o (ringing),
    .snoozed_o (snoozed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // k = cycles since RING entry; tone starts high, cadence starts ON.
  function automatic logic exp_buzz(input int k);
    return ((k % PERIOD) < ON_CYC) && (((k / HP) % 2) == 0);
  endfunction

  task automatic expect_at(input int off, input logic b, input logic r,
                           input logic s, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.b = b;
    e.r = r;
    e.s = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk = n_chk + 1;
      if (e.cyc != cyc) begin
        $display("FAIL %s: check for cycle %0d skipped (now %0d)", nm, e.cyc, cyc);
      end else if ({buzzer, ringing, snoozed} !== {e.b, e.r, e.s}) begin
        $display("FAIL %s @cyc %0d: buzzer/ringing/snoozed got %b%b%b expected %b%b%b",
                 nm, cyc, buzzer, ringing, snoozed, e.b, e.r, e.s);
      end else begin
        n_pass = n_pass + 1;
      end
    end
  end

  initial begin
    reset = 1'b1; state = ALARM; stop = 1'b0; snooze = 1'b0;
    #1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "reset_1");
    expect_at(2, 1'b0, 1'b0, 1'b0, "reset_2");
    step(2);
    reset = 1'b0;
    for (int k = 0; k < 36; k++) expect_at(1 + k, exp_buzz(k), 1'b1, 1'b0, "tone_cadence");
    step(36);

    stop = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "stop");
    step(1);
    stop = 1'b0;
    expect_at(8, 1'b0, 1'b0, 1'b0, "no_rering");
    step(8);
    state = OTHER;
    expect_at(1, 1'b0, 1'b0, 1'b0, "leave_alarm");
    step(1);
    state = ALARM;
    expect_at(1, 1'b1, 1'b1, 1'b0, "retrigger");
    step(3);
    snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
    expect_at(1, 1'b0, 1'b0, 1'b1, "snooze");
    step(1);
    snooze = 1'b0;
    expect_at(SNZ_CYC - 1, 1'b0, 1'b0, 1'b1, "snoozed_hold");
    expect_at(SNZ_CYC, 1'b1, 1'b1, 1'b0, "snooze_expire");
    step(SNZ_CYC + 2);
`else
    expect_at(1, exp_buzz(3), 1'b1, 1'b0, "snooze_ignored");
    step(1);
    snooze = 1'b0;
    expect_at(3, exp_buzz(6), 1'b1, 1'b0, "still_ringing");
    step(4);
`endif
    stop = 1'b1; snooze = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "stop_and_snooze");
    step(1);
    stop = 1'b0; snooze = 1'b0;

    state = OTHER;
    step(1);
    state = ALARM;
    expect_at(1, 1'b1, 1'b1, 1'b0, "trig_timeout");
    expect_at(TO_CYC, exp_buzz(TO_CYC - 1), 1'b1, 1'b0, "before_timeout");
    expect_at(TO_CYC + 1, 1'b0, 1'b0, 1'b0, "timeout");
    expect_at(TO_CYC + 8, 1'b0, 1'b0, 1'b0, "after_timeout");
    step(TO_CYC + 8);

    state = OTHER;
    step(1);
    state = ALARM;
    expect_at(1, 1'b1, 1'b1, 1'b0, "trig_stop_to");
    expect_at(TO_CYC, exp_buzz(TO_CYC - 1), 1'b1, 1'b0, "pre_stop_to");
    step(TO_CYC);
    stop = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "stop_with_timeout");
    step(1);
    stop = 1'b0;
    expect_at(4, 1'b0, 1'b0, 1'b0, "stop_to_idle");
    step(4);

    state = OTHER;
    step(1);
    state = ALARM;
    expect_at(1, 1'b1, 1'b1, 1'b0, "trig_mid_reset");
    step(2);
    reset = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "reset_mid_ring");
    step(1);
    reset = 1'b0;
    expect_at(1, 1'b1, 1'b1, 1'b0, "ring_after_reset");
    step(1);
    stop = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "final_stop");
    step(1);
    stop = 1'b0;
    step(4);

    n_lost = exp_q.size();
    while (exp_q.size() > 0) begin
      $display("FAIL %s: never checked (cycle %0d)", name_q[0], exp_q[0].cyc);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk + n_lost);
    $finish;
  end

endmodule
